// File: rtl/demux8_pkg.sv
// Shared definitions for the 8-channel TDM demultiplexer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: channel count, select width, full-frame mask, FSM state type and
// a one-hot decode helper used by the top level.
package demux8_pkg;

   localparam int NCH  = 8;
   localparam int SELW = 3;

   localparam logic [NCH-1:0] FULL_MASK = 8'hFF;

   typedef enum logic {
      FILL    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // Channel index to ch_valid bit position.
   function automatic logic [NCH-1:0] ch_onehot(input logic [SELW-1:0] idx);
      logic [NCH-1:0] one;
      one = {{(NCH-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/demux8_if.sv
// Bundle between the word source / frame consumer and demux8_tdm.
// Latency: n/a (wiring only).
// Backpressure: in_ready back to the source; frame_ack back from the consumer.
// Ports: in_data/in_valid/in_ready/sel (word side), out0..out7/ch_valid/
// frame_valid/frame_ack (frame side). master = driving environment, slave = demux.
interface demux8_if
   import demux8_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic [SELW-1:0]  sel;
   logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
   logic [NCH-1:0]   ch_valid;
   logic             frame_valid;
   logic             frame_ack;

   modport master (
      output in_data, in_valid, sel, frame_ack,
      input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
             ch_valid, frame_valid
   );

   modport slave (
      input  in_data, in_valid, sel, frame_ack,
      output in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
             ch_valid, frame_valid
   );
endinterface

// File: rtl/demux8_slot_ctr.sv
// 3-bit wrapping slot counter supplying the destination channel in auto-select mode.
// Latency: count updates one cycle after inc_i/clr_i.
// Backpressure: none; clr_i has priority over inc_i.
// Ports: clk, rst (sync, active-high), inc_i, clr_i, cnt_o.
module demux8_slot_ctr
   import demux8_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            inc_i,
   input  logic            clr_i,
   output logic [SELW-1:0] cnt_o
);

   logic [SELW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;   // natural 3-bit wrap 7->0
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/demux8_tdm.sv
// Scatters a time-multiplexed word stream into eight registered channels and
// presents a complete frame once every channel has been written.
// Latency: 1 cycle from accept to out[k]/ch_valid[k]; frame_valid on the same edge as the 8th distinct write.
// Backpressure: in_ready=1 only in FILL (and not in reset); frame held until frame_ack.
// Ports: clk, rst (sync, active-high), bus (demux8_if.slave).
// Build option: DEMUX8_AUTOSEL_EN takes the destination from an internal slot
// counter instead of bus.sel.
module demux8_tdm
   import demux8_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic     clk,
   input  logic     rst,
   demux8_if.slave  bus
);

   state_t           state_q, state_d;
   logic [NCH-1:0]   ch_valid_q, ch_valid_d;
   logic [WIDTH-1:0] ch_q [NCH];
   logic [SELW-1:0]  dest;
   logic             accept;
   logic             take;      // frame handed to the consumer this cycle
   logic             in_ready_w;

`ifdef DEMUX8_AUTOSEL_EN
   // Cleared on the PRESENT->FILL edge so every frame fills 0..7 in order.
   demux8_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst   (rst),
      .inc_i (accept),
      .clr_i (take),
      .cnt_o (dest)
   );
`else
   assign dest = bus.sel;
`endif

   always_comb begin
      state_d    = state_q;
      ch_valid_d = ch_valid_q;
      in_ready_w = 1'b0;
      accept     = 1'b0;
      take       = 1'b0;
      case (state_q)
         FILL: begin
            in_ready_w = !rst;
            accept     = bus.in_valid && in_ready_w;
            if (accept) begin
               ch_valid_d = ch_valid_q | ch_onehot(dest);
               if (ch_valid_d == FULL_MASK) begin
                  state_d = PRESENT;
               end
            end
         end
         PRESENT: begin
            if (bus.frame_ack) begin
               take       = 1'b1;
               ch_valid_d = '0;
               state_d    = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         ch_valid_q <= '0;
      end else begin
         state_q    <= state_d;
         ch_valid_q <= ch_valid_d;
      end
   end

   // Channel data only moves on accept; an ack leaves the last frame visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            ch_q[k] <= '0;
         end
      end else if (accept) begin
         ch_q[dest] <= bus.in_data;
      end
   end

   assign bus.in_ready    = in_ready_w;
   assign bus.frame_valid = (state_q == PRESENT);
   assign bus.ch_valid    = ch_valid_q;
   assign bus.out0        = ch_q[0];
   assign bus.out1        = ch_q[1];
   assign bus.out2        = ch_q[2];
   assign bus.out3        = ch_q[3];
   assign bus.out4        = ch_q[4];
   assign bus.out5        = ch_q[5];
   assign bus.out6        = ch_q[6];
   assign bus.out7        = ch_q[7];

endmodule

// File: doc/demux8_tdm.md
# demux8_tdm

Time-division demultiplexer for the 8-to-1 word mux: takes the single selected word stream and scatters it back into eight parallel registered channels. Incoming words are accepted under a valid/ready handshake, written to the addressed channel register, and tracked per channel. Once all eight channels have been written, the block presents a complete frame and holds it until the consumer acknowledges. It sits at the receive end of any path where eight operands were time-multiplexed onto one bus by the mux.

## Interface
- WIDTH, 8, data word width of input and of every channel output
- clk  input  1  rising-edge clock
- rst  input  1  one clock; reset is synchronous and active-high
- in_data  input  WIDTH  word to route
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- sel  input  3  destination channel 0..7 (ignored when DEMUX8_AUTOSEL_EN is defined)
- out0..out7  output  WIDTH each  registered channel words; index order matches mux inputs d0..d7
- ch_valid  output  8  bit k set = channel k written in the current frame
- frame_valid  output  1  all 8 channels written; outputs form a complete frame
- frame_ack  input  1  consumer has taken the frame

## Operation
- Two states: FILL and PRESENT.
- FILL:
  - in_ready=1.
  - A word is accepted when in_valid&&in_ready at a rising edge.
  - On accept: out[k] <= in_data and ch_valid[k] <= 1, where k = destination channel.
  - Rewriting an already-set channel overwrites the data; its ch_valid bit stays 1.
- FILL -> PRESENT: when the accept makes ch_valid all ones.
- PRESENT:
  - in_ready=0 and frame_valid=1.
  - Words offered here are not accepted; out0..out7 are frozen.
- PRESENT -> FILL: on frame_ack=1 at a rising edge. ch_valid clears to 0; out0..out7 keep their values; they are not cleared.
- frame_ack in FILL: ignored.
- Destination index is 3 bits; channel 7 is followed by channel 0, with no overflow flag.
- Reset (at any time, including mid-frame or during PRESENT):
  - state=FILL, out0..out7=0, ch_valid=0, frame_valid=0.
  - in_ready=0 while rst is high, 1 on the first cycle after release.

## Timing
- in_ready is decoded combinationally from state (and rst); it does not depend on in_valid.
- Write latency: 1 cycle. A word accepted at edge N is visible on out[k] and ch_valid[k] after edge N.
- frame_valid rises after the same edge that performs the 8th distinct channel write. No extra cycle is added.
- frame_ack accepted at edge M:
  - frame_valid=0, ch_valid=0 and in_ready=1 after edge M.
  - A new word can be accepted at edge M+1.
- Throughput in FILL: one word per cycle. A minimum frame is 8 accepts + 1 ack cycle.
- in_valid and in_ready together on the 8th write: the write lands and the state goes to PRESENT on the same edge.

## Configuration
- DEMUX8_AUTOSEL_EN defined:
  - Destination comes from an internal 3-bit slot counter; the sel port is present but ignored.
  - The counter resets to 0, increments on each accept and wraps 7->0.
  - The counter is forced to 0 on the PRESENT->FILL transition, so every frame fills 0..7 in order.
- DEMUX8_AUTOSEL_EN undefined: destination = sel, sampled at the accept edge; no counter is instantiated.

## Structure
- Package demux8_pkg:
  - NCH=8 and SELW=3.
  - State enum {FILL, PRESENT}.
  - Full-mask constant 8'hFF.
- Sub-module demux8_slot_ctr: 3-bit wrapping counter with inc and clear inputs. Instantiated only under DEMUX8_AUTOSEL_EN.
- Channel registers and ch_valid live in the top level as an 8-entry array, driven to out0..out7.

## Test plan
- Reset, then sel=0..7 with in_data=10..17, one per cycle and in_valid held high -> out_k=10+k. frame_valid rises after the 8th edge, in_ready falls to 0, ch_valid=8'hFF.
- In PRESENT, drive in_valid=1 with data 8'hAA for 3 cycles, then frame_ack=1 for 1 cycle -> out0..7 still 10..17 and ch_valid=0. in_ready=1 the cycle after the ack.
- Write sel=3 with data 5, then sel=3 with data 9, then the remaining 7 channels -> out3=9. frame_valid rises only after the 8th distinct channel, i.e. after 9 accepts.
- Assert rst for 1 cycle after 5 writes -> out0..7=0, ch_valid=0, frame_valid=0. A fresh 8-write frame then completes normally.
- Toggle in_valid 1,0,1,0 over 16 cycles with sel=0..7 -> exactly 8 accepts, and frame_valid rises after the 8th accept edge.
- With DEMUX8_AUTOSEL_EN defined and sel held at 5, stream 20..27 -> out_k=20+k. After the ack, stream 30..37 -> out0 receives 30, confirming the counter restarts at 0.
